// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int DATA_W      = 32;
  localparam int ITERS       = 32;
  localparam int HILO_BUS_WD = 66;

  // Operation encodings as they arrive from decode.
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_e;

  // Datapath mode for a single iteration.
  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

  // Bit 1 of the op selects divide, bit 0 selects unsigned.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] abs32(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide.
// Multiply: acc = {partial_hi, multiplier_remaining}, operand = multiplicand.
// Divide:   acc = {remainder, quotient/dividend},     operand = divisor.
module muldiv_step
  import muldiv_pkg::*;
(
  input  step_mode_e  mode,
  input  logic [63:0] acc,
  input  logic [31:0] operand,
  output logic [63:0] acc_next
);

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] rem_sh;
  logic [33:0] diff;
  logic [63:0] div_next;

  // Both step flavours computed in parallel, mode picks one.
  always_comb begin
    // Add multiplicand into the upper half when the low bit is set, then
    // shift the 65-bit {carry, acc} right by one.
    mul_sum  = acc[0] ? ({1'b0, acc[63:32]} + {1'b0, operand}) : {1'b0, acc[63:32]};
    mul_next = {mul_sum, acc[31:1]};

    // Shift {rem, quot} left; the remainder needs 33 bits before the trial
    // subtract since the shifted-out bit can be set.
    rem_sh   = acc[63:31];
    diff     = {1'b0, rem_sh} - {2'b00, operand};
    div_next = diff[33] ? {acc[62:0], 1'b0} : {diff[31:0], acc[30:0], 1'b1};

    acc_next = (mode == STEP_DIV) ? div_next : mul_next;
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer for EX: latches an op, iterates 32 steps through
// muldiv_step, fixes signs and presents a one-cycle hi/lo write bus.
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [1:0]             op_i,
  input  logic [31:0]            src_a_i,
  input  logic [31:0]            src_b_i,
  input  logic                   annul_i,
  output logic                   stallreq_o,
  output logic                   ready_o,
  output logic [HILO_BUS_WD-1:0] hilo_bus_o
);

  md_state_e               state;
  logic [1:0]              op_q;
  logic [31:0]             a_q;
  logic [31:0]             b_q;
  logic                    neg_res;
  logic                    neg_rem;
  logic [31:0]             operand;
  logic [63:0]             acc;
  logic [5:0]              cnt;
  logic                    ready_q;
  logic [HILO_BUS_WD-1:0]  bus_q;

  logic [63:0]             acc_next;
  step_mode_e              step_mode;
  logic [31:0]             mag_a;
  logic [31:0]             mag_b;
  logic [63:0]             prod_fix;
  logic [31:0]             quot_fix;
  logic [31:0]             rem_fix;

  assign step_mode = op_is_div(op_q) ? STEP_DIV : STEP_MUL;

  muldiv_step u_step (
    .mode     (step_mode),
    .acc      (acc),
    .operand  (operand),
    .acc_next (acc_next)
  );

  // Operand magnitudes and sign-corrected results, used in PREP and FIX.
  always_comb begin
    mag_a    = op_is_signed(op_q) ? abs32(a_q) : a_q;
    mag_b    = op_is_signed(op_q) ? abs32(b_q) : b_q;
    prod_fix = neg_res ? (~acc + 64'd1) : acc;
    quot_fix = neg_res ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem_fix  = neg_rem ? (~acc[63:32] + 32'd1) : acc[63:32];
  end

  // Stall the pipe while an op is accepted or in flight; DONE releases it
  // so the pipe advances in the same cycle the result is written.
  assign stallreq_o = ((state == ST_IDLE) && start_i && !annul_i) ||
                      (state == ST_PREP) || (state == ST_RUN) || (state == ST_FIX);

  assign ready_o    = ready_q;
  assign hilo_bus_o = bus_q;

  // Sequencer FSM with registered result bus; reset and annul both abort.
  always_ff @(posedge clk) begin
    if (rst || annul_i) begin
      state   <= ST_IDLE;
      op_q    <= 2'b00;
      a_q     <= '0;
      b_q     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      operand <= '0;
      acc     <= '0;
      cnt     <= '0;
      ready_q <= 1'b0;
      bus_q   <= '0;
    end else begin
      ready_q <= 1'b0;
      bus_q   <= '0;
      unique case (state)
        ST_IDLE: begin
          if (start_i) begin
            op_q  <= op_i;
            a_q   <= src_a_i;
            b_q   <= src_b_i;
            state <= ST_PREP;
          end
        end
        ST_PREP: begin
          cnt <= '0;
          if (op_is_div(op_q)) begin
            neg_res <= op_is_signed(op_q) && (a_q[31] ^ b_q[31]);
            neg_rem <= op_is_signed(op_q) && a_q[31];
            operand <= mag_b;
            acc     <= {32'd0, mag_a};
          end else begin
            neg_res <= op_is_signed(op_q) && (a_q[31] ^ b_q[31]);
            neg_rem <= 1'b0;
            operand <= mag_a;
            acc     <= {32'd0, mag_b};
          end
          if (op_is_div(op_q) && (b_q == 32'd0)) begin
            // Divide by zero: all-ones quotient, dividend passes through.
            ready_q <= 1'b1;
            bus_q   <= {2'b11, a_q, 32'hFFFF_FFFF};
            state   <= ST_DONE;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc <= acc_next;
          cnt <= cnt + 6'd1;
          if (cnt == 6'(ITERS - 1)) state <= ST_FIX;
        end
        ST_FIX: begin
          ready_q <= 1'b1;
          if (op_is_div(op_q)) bus_q <= {2'b11, rem_fix, quot_fix};
          else                 bus_q <= {2'b11, prod_fix};
          state <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: hand-computed results, latency, stall
// window, divide-by-zero, annul/reset aborts and back-to-back issue.
module tb_muldiv_ctrl;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic        annul_i;
  logic        stallreq_o;
  logic        ready_o;
  logic [65:0] hilo_bus_o;

  int total = 0;
  int bad   = 0;

  muldiv_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .src_a_i    (src_a_i),
    .src_b_i    (src_b_i),
    .annul_i    (annul_i),
    .stallreq_o (stallreq_o),
    .ready_o    (ready_o),
    .hilo_bus_o (hilo_bus_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Entered and left at posedge+1. Issues one op with start_i held, counts
  // stall cycles and finds the ready cycle. start_i is left high on return.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int exp_cyc, input logic [31:0] eh, input logic [31:0] el,
                       input string nm);
    logic [65:0] exp_bus;
    int cyc, stall_cnt;
    bit got;
    exp_bus = {2'b11, eh, el};
    cyc = 0; stall_cnt = 0; got = 0;
    start_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b;
    while (!got && cyc < 100) begin
      #1;
      if (stallreq_o) stall_cnt++;
      if (ready_o) begin
        got = 1;
        total++;
        if (cyc !== exp_cyc) begin
          bad++; $display("FAIL %s latency: got cycle %0d expected %0d", nm, cyc, exp_cyc);
        end
        total++;
        if (hilo_bus_o !== exp_bus) begin
          bad++; $display("FAIL %s bus: got %h expected %h", nm, hilo_bus_o, exp_bus);
        end
        total++;
        if (stallreq_o !== 1'b0) begin
          bad++; $display("FAIL %s stall_in_done: got %b expected 0", nm, stallreq_o);
        end
      end else if (hilo_bus_o !== 66'd0) begin
        total++; bad++;
        $display("FAIL %s bus_idle: got %h expected 0 at cycle %0d", nm, hilo_bus_o, cyc);
      end
      if (!got) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    total++;
    if (!got) begin
      bad++; $display("FAIL %s timeout: no ready within 100 cycles, expected at %0d", nm, exp_cyc);
    end
    total++;
    if (stall_cnt !== exp_cyc) begin
      bad++; $display("FAIL %s stall_cycles: got %0d expected %0d", nm, stall_cnt, exp_cyc);
    end
    @(posedge clk); #1;
  endtask

  // Step n cycles with start_i low, requiring no ready pulse and a zero bus.
  task automatic expect_quiet(input int n, input string nm);
    int seen;
    seen = 0;
    start_i = 1'b0; annul_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      if (ready_o !== 1'b0 || hilo_bus_o !== 66'd0 || stallreq_o !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL %s quiet: %0d active cycles, expected 0", nm, seen);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0;
    op_i = 2'b00; src_a_i = '0; src_b_i = '0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; #1;
    total++;
    if (ready_o !== 1'b0) begin bad++; $display("FAIL reset ready: got %b expected 0", ready_o); end
    total++;
    if (hilo_bus_o !== 66'd0) begin bad++; $display("FAIL reset bus: got %h expected 0", hilo_bus_o); end
    total++;
    if (stallreq_o !== 1'b0) begin bad++; $display("FAIL reset stall: got %b expected 0", stallreq_o); end
    start_i = 1'b1; #1;
    total++;
    if (stallreq_o !== 1'b1) begin bad++; $display("FAIL reset stall_on_start: got %b expected 1", stallreq_o); end
    start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_multu();
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    start_i = 1'b0;
    #1;
    total++;
    if (ready_o !== 1'b0 || hilo_bus_o !== 66'd0) begin
      bad++; $display("FAIL multu_after: ready=%b bus=%h expected 0/0", ready_o, hilo_bus_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 35, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg3x7");
    start_i = 1'b0; @(posedge clk); #1;
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 35, 32'h4000_0000, 32'h0, "mult_min_sq");
    start_i = 1'b0; @(posedge clk); #1;
  endtask

  task automatic test_div();
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 35, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2");
    start_i = 1'b0; @(posedge clk); #1;
    do_op(2'b11, 32'd100, 32'd7, 35, 32'd2, 32'd14, "divu_100by7");
    start_i = 1'b0; @(posedge clk); #1;
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 35, 32'h0, 32'h8000_0000, "div_min_by_m1");
    start_i = 1'b0; @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    do_op(2'b10, 32'd5, 32'd0, 2, 32'd5, 32'hFFFF_FFFF, "div_by_zero");
    start_i = 1'b0; @(posedge clk); #1;
  endtask

  task automatic test_annul();
    start_i = 1'b1; op_i = 2'b01; src_a_i = 32'd5; src_b_i = 32'd6;
    repeat (12) @(posedge clk);
    #1; annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0; start_i = 1'b0; #1;
    total++;
    if (stallreq_o !== 1'b0) begin bad++; $display("FAIL annul idle_stall: got %b expected 0", stallreq_o); end
    @(posedge clk); #1;
    expect_quiet(40, "annul_run");
    // Annul with start in IDLE: annul wins, no stall, nothing accepted.
    start_i = 1'b1; annul_i = 1'b1; #1;
    total++;
    if (stallreq_o !== 1'b0) begin bad++; $display("FAIL annul_start stall: got %b expected 0", stallreq_o); end
    repeat (3) @(posedge clk);
    #1;
    expect_quiet(40, "annul_start");
  endtask

  task automatic test_rst_abort();
    start_i = 1'b1; op_i = 2'b11; src_a_i = 32'd100; src_b_i = 32'd7;
    repeat (20) @(posedge clk);
    #1; rst = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    expect_quiet(40, "rst_abort");
    // A fresh op after the aborts must not see stale operands.
    do_op(2'b11, 32'd100, 32'd7, 35, 32'd2, 32'd14, "divu_after_abort");
    start_i = 1'b0; @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    // start_i stays high across both ops: second accepted the cycle after DONE.
    do_op(2'b01, 32'd3, 32'd4, 35, 32'd0, 32'd12, "b2b_multu");
    do_op(2'b11, 32'd9, 32'd2, 35, 32'd1, 32'd4, "b2b_divu");
    start_i = 1'b0; @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_zero();
    test_annul();
    test_rst_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Iterative multiply/divide sequencer for the EX stage. It accepts mult/multu/div/divu operations, runs a shared 32-step shift-add / restoring-divide datapath, and holds the pipeline with a stall request until the result is ready. The result leaves as a one-cycle 66-bit hi/lo write bus with the same {hi_we, lo_we, hi, lo} layout that MEM/WB carry to the hi/lo registers and to the ID forwarding path.

## Interface
Parameters:
- none; the data width is fixed at 32 and the iteration count at 32.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  a valid mul/div instruction is in EX. Held high by the stalled pipeline while stallreq_o=1.
- op_i  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
- src_a_i  in  32  multiplicand or dividend.
- src_b_i  in  32  multiplier or divisor.
- annul_i  in  1  flush; cancels any operation in progress.
- stallreq_o  out  1  stall request to the stall controller.
- ready_o  out  1  result valid for this cycle.
- hilo_bus_o  out  66  {hi_we, lo_we, hi[31:0], lo[31:0]}. Both write enables equal ready_o; all 66 bits are 0 when ready_o=0.

## Operation
- FSM states: IDLE, PREP, RUN, FIX, DONE.
- IDLE: if start_i=1 and annul_i=0, latch op_i, src_a_i and src_b_i, then go to PREP.
- PREP:
  - For signed ops, take absolute values of the operands and record the result signs.
  - Clear the 64-bit accumulator and the 6-bit counter.
  - divisor==0 (div/divu): go straight to DONE with lo=32'hFFFF_FFFF, hi=src_a (unmodified).
  - Otherwise go to RUN.
- RUN: one step per cycle; counter runs 0..31; after step 31 go to FIX.
  - Multiply step: if acc[0]=1, add the 33-bit multiplicand to acc[63:32]; then shift the 65-bit {carry, acc} right by one.
  - Divide step (restoring): shift {rem, quot} left by one, trial-subtract the divisor from rem; if the result is non-negative, keep it and set quot[0]=1.
- FIX: sign correction.
  - mult: negate the 64-bit product if the operand signs differ.
  - div: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - Place results: mult gives hi=product[63:32], lo=product[31:0]; div gives hi=remainder, lo=quotient.
  - Go to DONE.
- DONE: ready_o=1 and hilo_bus_o is driven for exactly one cycle; next state is IDLE.
- stallreq_o = (state==IDLE & start_i & ~annul_i) | state∈{PREP, RUN, FIX}. It is 0 in DONE, so the pipeline advances in the same cycle the result is presented.
- Arithmetic rules:
  - 0x80000000 / -1 signed: lo=0x80000000, hi=0 (wraps, no trap).
  - mult of 0x80000000 × 0x80000000 signed: {hi, lo}=0x4000_0000_0000_0000.
- annul_i in any state: next state is IDLE, no ready pulse, and latched operands are discarded. annul_i together with start_i in IDLE: annul wins and stallreq_o=0.
- rst: same effect as annul_i. A mid-operation reset aborts with no output.

## Timing
- Start is sampled in IDLE at cycle 0.
- Normal path: PREP at cycle 1, RUN at cycles 2–33, FIX at 34, DONE at 35. stallreq_o is high for cycles 0–34; ready_o is high at cycle 35. Occupancy is 36 cycles.
- Divide by zero: PREP at cycle 1, DONE at cycle 2; stallreq_o is high for cycles 0–1.
- Back-to-back: start_i high in the cycle after DONE begins a new operation with no bubble.
- Reset values: state=IDLE, ready_o=0, hilo_bus_o=66'b0; stallreq_o=0 (it goes high only if start_i is asserted).
- Outputs are registered, except stallreq_o, which is combinational from state, start_i and annul_i.

## Structure
- Shared defines file: op encodings (MD_MULT/MULTU/DIV/DIVU), FSM state encodings, `HILO_BUS_WD = 66`.
- One sub-module, muldiv_step: combinational single-iteration datapath.
  - Inputs: mode, acc[63:0], operand[31:0].
  - Output: next acc.
  - Instantiated once; muldiv_ctrl owns the FSM, counter, sign fix and output register.

## Test plan
- multu 0xFFFFFFFF×0xFFFFFFFF: stall for 35 cycles, then one ready cycle with bus={1, 1, 0xFFFFFFFE, 0x00000001}.
- mult -3×7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; mult 0x80000000×0x80000000 → hi=0x40000000, lo=0.
- div -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 100/7 → lo=14, hi=2; div 0x80000000/-1 → lo=0x80000000, hi=0.
- div 5/0 → ready at cycle 2 with lo=0xFFFFFFFF, hi=5; stallreq_o low from cycle 2.
- annul_i at RUN cycle 10 → IDLE next cycle, ready_o never pulses, hilo_bus_o stays 0; rst at cycle 20 of a second op has the same effect.
- Back-to-back multu 3×4 then divu 9/2 with start_i held → ready at cycle 35 (lo=12) and at cycle 71 (lo=4, hi=1); no extra idle cycle between them.
